// File: rtl/tmvp_stream_sequencer.sv
// Stream sequencer for one Toeplitz matrix-vector product. It reads the first row, the first
// column and the vector from synchronous-read buffers and feeds the multiplier 2N-1 beats in
// order. The N product words are then written to the result buffer and done is pulsed.
module tmvp_stream_sequencer #(
    parameter int unsigned N          = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mat_rd_en,
    output logic                  mat_rd_sel,
    output logic [ADDR_WIDTH-1:0] mat_rd_addr,
    input  logic [DATA_WIDTH-1:0] mat_rd_data,
    output logic                  vec_rd_en,
    output logic [ADDR_WIDTH-1:0] vec_rd_addr,
    input  logic [DATA_WIDTH-1:0] vec_rd_data,
    output logic [DATA_WIDTH-1:0] mul_tdata_row,
    output logic [DATA_WIDTH-1:0] mul_tdata_vec,
    output logic                  mul_tvalid,
    input  logic [DATA_WIDTH-1:0] mul_out_tdata,
    input  logic                  mul_out_tvalid,
    output logic                  res_wr_en,
    output logic [ADDR_WIDTH-1:0] res_wr_addr,
    output logic [DATA_WIDTH-1:0] res_wr_data
);

    // One extra bit so the issue index reaches 2N-2 and the output count reaches N.
    localparam int unsigned CntWidth = ADDR_WIDTH + 1;
    localparam logic [CntWidth-1:0] KLast  = CntWidth'(2 * N - 2);
    localparam logic [CntWidth-1:0] NumOut = CntWidth'(N);
    localparam logic [CntWidth-1:0] One    = CntWidth'(1);

    typedef enum logic [2:0] {StIdle, StIssue, StDrain, StCollect, StDone} state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   k_q, k_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic                  drain_q, drain_d;
    logic                  err_d;
    logic                  active, wr_fire, stray;

    logic                  busy_d, done_d;
    logic                  mat_rd_en_d, mat_rd_sel_d, vec_rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_d;
    logic                  issue_d, hi_d;

    // Read-response stage: data arrives one cycle after the strobe.
    logic                  rsp_valid_q, rsp_zero_q;

    // Result collection: zero-latency write of each accepted multiplier output.
    always_comb begin
        active      = (state_q == StIssue) || (state_q == StDrain) || (state_q == StCollect);
        wr_fire     = active && mul_out_tvalid && (count_q != NumOut);
        stray       = mul_out_tvalid && !wr_fire;
        res_wr_en   = wr_fire;
        res_wr_addr = wr_fire ? count_q[ADDR_WIDTH-1:0] : '0;
        res_wr_data = wr_fire ? mul_out_tdata : '0;
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            count_q <= '0;
            drain_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            count_q <= count_d;
            drain_q <= drain_d;
            err     <= err_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        count_d = count_q;
        drain_d = drain_q;
        err_d   = err_q_or_stray();
        if (wr_fire) begin
            count_d = count_q + One;
        end
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    k_d     = '0;
                    count_d = '0;
                    err_d   = stray;
                end
            end
            StIssue: begin
                if (k_q == KLast) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end else begin
                    k_d = k_q + One;
                end
            end
            StDrain: begin
                if (drain_q) begin
                    state_d = StCollect;
                end else begin
                    drain_d = 1'b1;
                end
            end
            StCollect: begin
                // Look at the post-write count so the Nth write is followed directly by done.
                if (count_d == NumOut) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    function automatic logic err_q_or_stray();
        return err | stray;
    endfunction

    // Next values of the registered status and read-port outputs.
    always_comb begin
        issue_d      = (state_d == StIssue);
        hi_d         = (k_d >= NumOut);
        busy_d       = (state_d != StIdle);
        done_d       = (state_d == StDone);
        mat_rd_en_d  = issue_d;
        mat_rd_sel_d = issue_d && hi_d;
        vec_rd_en_d  = issue_d && !hi_d;
        rd_addr_d    = '0;
        if (issue_d) begin
            // Row is walked backwards from N-1, then column forwards from 1.
            rd_addr_d = hi_d ? ADDR_WIDTH'(k_d - NumOut + One)
                             : ADDR_WIDTH'(NumOut - One - k_d);
        end
    end

    // Registered outputs and the beat pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy          <= 1'b0;
            done          <= 1'b0;
            mat_rd_en     <= 1'b0;
            mat_rd_sel    <= 1'b0;
            mat_rd_addr   <= '0;
            vec_rd_en     <= 1'b0;
            vec_rd_addr   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_zero_q    <= 1'b0;
            mul_tvalid    <= 1'b0;
            mul_tdata_row <= '0;
            mul_tdata_vec <= '0;
        end else begin
            busy          <= busy_d;
            done          <= done_d;
            mat_rd_en     <= mat_rd_en_d;
            mat_rd_sel    <= mat_rd_sel_d;
            mat_rd_addr   <= rd_addr_d;
            vec_rd_en     <= vec_rd_en_d;
            vec_rd_addr   <= vec_rd_en_d ? rd_addr_d : '0;
            rsp_valid_q   <= mat_rd_en;
            rsp_zero_q    <= mat_rd_en && !vec_rd_en;
            mul_tvalid    <= rsp_valid_q;
            mul_tdata_row <= rsp_valid_q ? mat_rd_data : '0;
            mul_tdata_vec <= (rsp_valid_q && !rsp_zero_q) ? vec_rd_data : '0;
        end
    end

endmodule

// File: tb/tb_tmvp_stream_sequencer.sv
// Self-checking bench for tmvp_stream_sequencer: buffer and multiplier stubs plus a
// reference model of the beat order, result placement and done/err timing.
module tb_tmvp_stream_sequencer;

    localparam int N  = 16;
    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy, done, err;
    logic          mat_rd_en, mat_rd_sel;
    logic [AW-1:0] mat_rd_addr;
    logic [DW-1:0] mat_rd_data;
    logic          vec_rd_en;
    logic [AW-1:0] vec_rd_addr;
    logic [DW-1:0] vec_rd_data;
    logic [DW-1:0] mul_tdata_row, mul_tdata_vec;
    logic          mul_tvalid;
    logic [DW-1:0] mul_out_tdata;
    logic          mul_out_tvalid;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic [DW-1:0] res_wr_data;

    always #5 clk = ~clk;

    tmvp_stream_sequencer #(
        .N          (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .mat_rd_en      (mat_rd_en),
        .mat_rd_sel     (mat_rd_sel),
        .mat_rd_addr    (mat_rd_addr),
        .mat_rd_data    (mat_rd_data),
        .vec_rd_en      (vec_rd_en),
        .vec_rd_addr    (vec_rd_addr),
        .vec_rd_data    (vec_rd_data),
        .mul_tdata_row  (mul_tdata_row),
        .mul_tdata_vec  (mul_tdata_vec),
        .mul_tvalid     (mul_tvalid),
        .mul_out_tdata  (mul_out_tdata),
        .mul_out_tvalid (mul_out_tvalid),
        .res_wr_en      (res_wr_en),
        .res_wr_addr    (res_wr_addr),
        .res_wr_data    (res_wr_data)
    );

    logic [DW-1:0] row_mem [N];
    logic [DW-1:0] col_mem [N];
    logic [DW-1:0] vec_mem [N];
    logic [DW-1:0] res_got [N];

    int n_checks;
    int n_fail;
    bit err_model;

    // Synchronous-read operand buffers.
    always @(posedge clk) begin
        if (mat_rd_en) mat_rd_data <= mat_rd_sel ? col_mem[mat_rd_addr] : row_mem[mat_rd_addr];
        if (vec_rd_en) vec_rd_data <= vec_mem[vec_rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, err, mat_rd_en, mat_rd_sel, mat_rd_addr, vec_rd_en, vec_rd_addr,
                    mul_tdata_row, mul_tdata_vec, mul_tvalid, res_wr_en, res_wr_addr,
                    res_wr_data});
    endfunction

    task automatic fill_mem(input bit patterned);
        for (int i = 0; i < N; i++) begin
            row_mem[i] = patterned ? DW'(8'h10 + i) : DW'($urandom);
            col_mem[i] = patterned ? DW'(8'h20 + i) : DW'($urandom);
            vec_mem[i] = patterned ? DW'(8'h30 + i) : DW'($urandom);
        end
    endtask

    // One operation. Cycle 0 is the cycle where start is sampled. Outputs come back at
    // first_out with gaps of 1..max_gap; spur_off > 0 adds one extra output after the last.
    task automatic run_op(input int first_out, input int max_gap, input int spur_off,
                          input int hold_len, input int abort_at, input bit pat_words);
        int            out_cyc [N];
        logic [DW-1:0] words [N];
        logic [DW-1:0] exp_row [$];
        logic [DW-1:0] exp_vec [$];
        int            done_exp, spur_cyc, idx, stop;
        bit            exp_wr, beat;
        logic [DW-1:0] er, ev;

        out_cyc[0] = first_out;
        for (int i = 1; i < N; i++)
            out_cyc[i] = out_cyc[i-1] + ((max_gap > 1) ? int'($urandom_range(1, max_gap)) : 1);
        for (int i = 0; i < N; i++) begin
            words[i]   = pat_words ? DW'(8'hA0 + i) : DW'($urandom);
            res_got[i] = 'x;
        end
        // Done follows the later of the last write and the fixed issue+drain window.
        done_exp = (out_cyc[N-1] + 1 > 2 * N + 3) ? out_cyc[N-1] + 1 : 2 * N + 3;
        spur_cyc = -1;
        if (spur_off > 0)
            spur_cyc = (out_cyc[N-1] + spur_off > done_exp) ? done_exp : out_cyc[N-1] + spur_off;
        // Toeplitz stream: first row from its last element down, then column from index 1.
        for (int j = 0; j < N; j++) begin
            exp_row.push_back(row_mem[N-1-j]);
            exp_vec.push_back(vec_mem[N-1-j]);
        end
        for (int j = 1; j < N; j++) begin
            exp_row.push_back(col_mem[j]);
            exp_vec.push_back('0);
        end

        idx  = 0;
        stop = (abort_at >= 0) ? abort_at : done_exp;
        for (int c = 0; c <= stop; c++) begin
            @(posedge clk);
            #1;
            start          = (c < hold_len);
            exp_wr         = (idx < N) && (c == out_cyc[idx]);
            mul_out_tvalid = exp_wr || (c == spur_cyc);
            mul_out_tdata  = exp_wr ? words[idx] : DW'($urandom);
            if (c == abort_at) begin
                #2 reset = 1'b1;
                #1 check("reset_mid_outs", all_outs(), '0);
                @(negedge clk);
                #1;
                reset          = 1'b0;
                start          = 1'b0;
                mul_out_tvalid = 1'b0;
                err_model      = 1'b0;
                return;
            end
            @(negedge clk);
            check("busy", 64'(busy), 64'(c >= 1));
            check("done", 64'(done), 64'(c == done_exp));
            check("err", 64'(err),
                  64'((c == 0) ? err_model : (spur_cyc >= 0 && c > spur_cyc)));
            check("mat_rd_en", 64'(mat_rd_en), 64'(c >= 1 && c <= 2 * N - 1));
            check("vec_rd_en", 64'(vec_rd_en), 64'(c >= 1 && c <= N));
            beat = (c >= 3) && (c <= 2 * N + 1);
            er   = '0;
            ev   = '0;
            if (beat) begin
                er = exp_row[c-3];
                ev = exp_vec[c-3];
            end
            check("mul_tvalid", 64'(mul_tvalid), 64'(beat));
            check("beat_row", 64'(mul_tdata_row), 64'(er));
            check("beat_vec", 64'(mul_tdata_vec), 64'(ev));
            check("res_wr_en", 64'(res_wr_en), 64'(exp_wr));
            if (res_wr_en === 1'b1) res_got[res_wr_addr] = res_wr_data;
            if (exp_wr) begin
                check("res_wr_addr", 64'(res_wr_addr), 64'(idx));
                check("res_wr_data", 64'(res_wr_data), 64'(words[idx]));
                idx++;
            end
        end
        err_model = (spur_cyc >= 0);
        for (int i = 0; i < N; i++) check("result_buf", 64'(res_got[i]), 64'(words[i]));
    endtask

    // Idle cycles; optionally one stray multiplier output on the first of them.
    task automatic idle_cycles(input int n, input bit spur);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start          = 1'b0;
            mul_out_tvalid = spur && (c == 0);
            mul_out_tdata  = DW'($urandom);
            @(negedge clk);
            check("idle_busy", 64'(busy), 64'(0));
            check("idle_done", 64'(done), 64'(0));
            check("idle_tvalid", 64'(mul_tvalid), 64'(0));
            check("idle_wr_en", 64'(res_wr_en), 64'(0));
            check("idle_err", 64'(err), 64'(err_model));
            if (spur && c == 0) err_model = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        err_model      = 1'b0;
        reset          = 1'b1;
        start          = 1'b0;
        mul_out_tvalid = 1'b0;
        mul_out_tdata  = '0;
        fill_mem(1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", all_outs(), '0);
        reset = 1'b0;

        // Fixed operands, outputs 0xA0.. on cycles 40..55.
        run_op(40, 1, 0, 1, -1, 1'b1);
        idle_cycles(1, 1'b0);
        // All outputs arrive during issue.
        run_op(10, 1, 0, 1, -1, 1'b0);
        idle_cycles(2, 1'b0);
        // Extra output in DONE, then a stray one in IDLE.
        run_op(40, 1, 1, 1, -1, 1'b0);
        idle_cycles(3, 1'b1);
        // Start clears err; extra output while still issuing.
        run_op(10, 1, 1, 1, -1, 1'b0);
        idle_cycles(2, 1'b0);
        // Start held for 40 cycles: one run, then a second starting after done.
        run_op(10, 1, 0, 40, -1, 1'b0);
        run_op(10, 1, 0, 4, -1, 1'b0);
        idle_cycles(1, 1'b0);
        // Asynchronous reset on cycle 12, then a full run.
        run_op(40, 1, 0, 1, 12, 1'b0);
        idle_cycles(2, 1'b0);
        run_op(40, 1, 0, 1, -1, 1'b1);
        idle_cycles(1, 1'b0);

        for (int r = 0; r < 20; r++) begin
            fill_mem(1'b0);
            run_op(int'($urandom_range(1, 40)), 3,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                   int'($urandom_range(1, 6)), -1, 1'b0);
            idle_cycles(int'($urandom_range(0, 2)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
